// File: rtl/gpr_read_port.sv
// Operand-fetch read port: samples two GPR operands per request and queues them in a small FIFO.
// Optional write-port bypass is enabled by defining GPR_READ_BYPASS_EN.
module gpr_read_port #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_src_a,
  input  logic [3:0]  req_src_b,
  input  logic [31:0] eax,
  input  logic [31:0] ecx,
  input  logic [31:0] edx,
  input  logic [31:0] ebx,
  input  logic [31:0] esp,
  input  logic [31:0] ebp,
  input  logic [31:0] edi,
  input  logic [31:0] esi,
  input  logic [3:0]  read_or_write,
  input  logic [31:0] write_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_err
);

  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     gpr [8];
  logic [31:0]     opnd_a, opnd_b;
  logic            opnd_err;
  logic            push, pop;

  logic [31:0]     a_q [DEPTH];
  logic [31:0]     a_d [DEPTH];
  logic [31:0]     b_q [DEPTH];
  logic [31:0]     b_d [DEPTH];
  logic            err_q [DEPTH];
  logic            err_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  assign gpr[0] = eax;
  assign gpr[1] = ecx;
  assign gpr[2] = edx;
  assign gpr[3] = ebx;
  assign gpr[4] = esp;
  assign gpr[5] = ebp;
  assign gpr[6] = edi;
  assign gpr[7] = esi;

  // Codes 8-F are illegal: operand reads as zero and the entry is flagged.
  always_comb begin
    opnd_a   = req_src_a[3] ? 32'h0 : gpr[req_src_a[2:0]];
    opnd_b   = req_src_b[3] ? 32'h0 : gpr[req_src_b[2:0]];
    opnd_err = req_src_a[3] | req_src_b[3];
`ifdef GPR_READ_BYPASS_EN
    if (!req_src_a[3] && (read_or_write == req_src_a)) opnd_a = write_data;
    if (!req_src_b[3] && (read_or_write == req_src_b)) opnd_b = write_data;
`endif
  end

`ifndef GPR_READ_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{read_or_write, write_data};
`endif

  // Handshake flags depend only on the registered count.
  assign req_ready = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = req_valid && req_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      a_d[tail_q]   = opnd_a;
      b_d[tail_q]   = opnd_b;
      err_d[tail_q] = opnd_err;
      tail_d        = (tail_q == PtrW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == PtrW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      err_q   <= '{default: 1'b0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_a   = out_valid ? a_q[head_q]   : 32'h0;
  assign out_b   = out_valid ? b_q[head_q]   : 32'h0;
  assign out_err = out_valid ? err_q[head_q] : 1'b0;

endmodule

// File: tb/tb_gpr_read_port.sv
// Self-checking bench for gpr_read_port: directed scenarios plus random traffic against a queue model.
module tb_gpr_read_port;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_src_a = '0;
  logic [3:0]  req_src_b = '0;
  logic [31:0] regs [8];
  logic [3:0]  rw = 4'hF;
  logic [31:0] wd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_err;
  logic [66:0] obs;

  entry_t model_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  gpr_read_port #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src_a    (req_src_a),
    .req_src_b    (req_src_b),
    .eax          (regs[0]),
    .ecx          (regs[1]),
    .edx          (regs[2]),
    .ebx          (regs[3]),
    .esp          (regs[4]),
    .ebp          (regs[5]),
    .edi          (regs[6]),
    .esi          (regs[7]),
    .read_or_write(rw),
    .write_data   (wd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_err      (out_err)
  );

  assign obs = {out_valid, req_ready, out_err, out_a, out_b};

  function automatic logic [31:0] ref_read(input int code);
    if (code > 7) return 32'h0;
`ifdef GPR_READ_BYPASS_EN
    if (int'(rw) == code) return wd;
`endif
    return regs[code];
  endfunction

  // Expected {out_valid, req_ready, out_err, out_a, out_b} from the model queue.
  function automatic logic [66:0] exp_vec();
    entry_t h;
    if (model_q.size() == 0) return {1'b0, 1'b1, 1'b0, 64'h0};
    h = model_q[0];
    return {1'b1, (model_q.size() != DEPTH), h.err, h.a, h.b};
  endfunction

  // Advance one clock, applying the same edge to the model; leaves time 1 unit after the edge.
  task automatic cycle();
    bit     push, pop;
    entry_t e;
    push = req_valid && (model_q.size() != DEPTH);
    pop  = out_ready && (model_q.size() != 0);
    e.a   = ref_read(int'(req_src_a));
    e.b   = ref_read(int'(req_src_b));
    e.err = (req_src_a > 4'd7) || (req_src_b > 4'd7);
    @(posedge clock);
    if (reset) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    total++;
    if (obs !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", obs, {1'b0, 1'b1, 1'b0, 64'h0});
    end
  endtask

  task automatic test_basic();
    regs[6]   = 32'h0000_0888;
    regs[0]   = 32'h1234_5678;
    req_src_a = 4'd6;
    req_src_b = 4'd0;
    out_ready = 1'b1;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    total++;
    if ({out_valid, out_a, out_b} !== {1'b1, 32'h888, 32'h1234_5678}) begin
      bad++;
      $display("FAIL basic_read: got %h want %h", {out_valid, out_a, out_b},
               {1'b1, 32'h888, 32'h1234_5678});
    end
    cycle();
    total++;
    if (obs !== exp_vec() || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_empty: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 8; r++) regs[r] = $urandom;
      req_src_a = 4'($urandom_range(0, 7));
      req_src_b = 4'($urandom_range(0, 7));
      cycle();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL fill_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready: got %b want 0", req_ready);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 && model_q.size() != 0; i++) begin
      cycle();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL drain_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drained_flags: got ready=%b valid=%b want ready=1 valid=0",
               req_ready, out_valid);
    end
  endtask

  task automatic test_illegal();
    regs[3]   = 32'hCAFE_0003;
    req_src_a = 4'h9;
    req_src_b = 4'd3;
    out_ready = 1'b0;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    total++;
    if ({out_err, out_a, out_b} !== {1'b1, 32'h0, 32'hCAFE_0003}) begin
      bad++;
      $display("FAIL illegal_code: got %h want %h", {out_err, out_a, out_b},
               {1'b1, 32'h0, 32'hCAFE_0003});
    end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    regs[6]   = 32'h0BAD_F00D;
    rw        = 4'd6;
    wd        = 32'hDEAD_BEEF;
`ifdef GPR_READ_BYPASS_EN
    want = 32'hDEAD_BEEF;
`else
    want = 32'h0BAD_F00D;
`endif
    req_src_a = 4'd6;
    req_src_b = 4'd6;
    out_ready = 1'b0;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    total++;
    if ({out_a, out_b} !== {want, want}) begin
      bad++;
      $display("FAIL bypass: got %h %h want %h", out_a, out_b, want);
    end
    rw        = 4'hF;
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid = 1'b1;
    req_src_a = 4'd1;
    req_src_b = 4'd2;
    cycle();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_fill: got valid=%b want 1", out_valid);
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    cycle();
    reset     = 1'b0;
    req_valid = 1'b0;
    total++;
    if (obs !== {1'b0, 1'b1, 1'b0, 64'h0}) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs, {1'b0, 1'b1, 1'b0, 64'h0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 8; r++) regs[r] = $urandom;
      req_src_a = 4'($urandom_range(0, 15));
      req_src_b = 4'($urandom_range(0, 15));
      rw        = 4'($urandom_range(0, 15));
      wd        = $urandom;
      req_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 59) == 0);
      cycle();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    reset     = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) regs[r] = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
